// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop RxD synchronizer, mid-bit sampling FSM and a
// single-byte holding register with ready/acknowledge, framing-error and overrun flags.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int CNT_W        = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_e;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e            state_q,      state_d;
    logic              rx_meta_q,    rx_meta_d;
    logic              rx_s_q,       rx_s_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [2:0]        bit_idx_q,    bit_idx_d;
    logic [7:0]        shift_q,      shift_d;
    logic [7:0]        rx_data_q,    rx_data_d;
    logic              data_ready_q, data_ready_d;
    logic              frame_err_q,  frame_err_d;
    logic              overrun_q,    overrun_d;

    // NOTE: every variable gets its hold/default value before the case, so no
    // path through this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rx_meta_d    = RxD;
        rx_s_d       = rx_meta_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        data_ready_d = data_ready_q;
        overrun_d    = overrun_q;
        frame_err_d  = 1'b0;

        if (rd_ack && data_ready_q) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end

            // Re-check the line half a bit in; a high here was only a glitch.
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    cnt_d              = '0;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // A capture overrides a same-cycle rd_ack: the new byte stays pending.
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        rx_data_d    = shift_q;
                        data_ready_d = 1'b1;
                        if (data_ready_q && !rd_ack) begin
                            overrun_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizer presets to the idle line level so reset never looks like a start bit.
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            data_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            data_ready_q <= data_ready_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign data_ready = data_ready_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus randomized traffic,
// compared against a byte-level model of the receive handshake.
module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       RxD;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    uart_receiver #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RxD       (RxD),
        .rd_ack    (rd_ack),
        .rx_data   (rx_data),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Model of what the consumer should see.
    logic [7:0] exp_data;
    logic       exp_ready;
    logic       exp_overrun;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_ready"},   32'(data_ready), 32'(exp_ready));
        check({tag, "_data"},    32'(rx_data),    32'(exp_data));
        check({tag, "_overrun"}, 32'(overrun),    32'(exp_overrun));
    endtask

    task automatic model_reset();
        exp_data    = 8'h00;
        exp_ready   = 1'b0;
        exp_overrun = 1'b0;
    endtask

    // Drives one 10-bit frame starting at a negedge and checks the stop-sample edge,
    // which falls 2 + HALF + 9*CPB clocks after the start edge reaches the receiver.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic ack_at_stop);
        logic [9:0] line;
        line = {stop_bit, data, 1'b0};
        for (int i = 0; i < 9; i++) begin
            RxD = line[i];
            tick(CPB);
        end
        RxD = stop_bit;
        tick(2 + HALF);
        check_state("pre_stop");
        check("pre_stop_ferr", 32'(frame_err), 32'd0);
        check("pre_stop_busy", 32'(busy), 32'd1);
        if (ack_at_stop) rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
        if (stop_bit) begin
            if (exp_ready && !ack_at_stop) exp_overrun = 1'b1;
            else if (ack_at_stop)          exp_overrun = 1'b0;
            exp_ready = 1'b1;
            exp_data  = data;
        end else if (ack_at_stop && exp_ready) begin
            exp_ready   = 1'b0;
            exp_overrun = 1'b0;
        end
        check_state("post_stop");
        check("post_stop_ferr", 32'(frame_err), 32'(!stop_bit));
        check("post_stop_busy", 32'(busy), 32'(!stop_bit));
        tick(1);
        check("ferr_one_cycle", 32'(frame_err), 32'd0);
        tick(CPB - HALF - 4);
    endtask

    // Line held low after a bad stop: receiver must stay busy and quiet until it rises.
    task automatic hold_break(input int hold);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick(1);
            if (!busy || frame_err || data_ready !== exp_ready) bad = 1'b1;
        end
        check("break_quiet", 32'(bad), 32'd0);
        RxD = 1'b1;
        tick(2);
        check("break_busy_until_high", 32'(busy), 32'd1);
        tick(1);
        check("break_exit_idle", 32'(busy), 32'd0);
    endtask

    task automatic ack_pulse(input string tag);
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
        if (exp_ready) begin
            exp_ready   = 1'b0;
            exp_overrun = 1'b0;
        end
        check_state(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int busy_cycles;
        logic ferr_seen;
        logic [7:0] rnd_data;
        logic       rnd_stop;
        int         mode;

        rst    = 1'b1;
        RxD    = 1'b1;
        rd_ack = 1'b0;
        model_reset();
        tick(3);
        check_state("reset");
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(5);

        // Basic frame with exact latency, then acknowledge and an ignored second ack.
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_data", 32'(rx_data), 32'hA5);
        ack_pulse("a5_ack");
        ack_pulse("idle_ack_ignored");
        tick(7);

        // Back-to-back frames without acknowledge produce an overrun.
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        check("ovr_data", 32'(rx_data), 32'hC3);
        check("ovr_flag", 32'(overrun), 32'd1);
        ack_pulse("ovr_ack");
        tick(4);

        // Bad stop bit followed by a held-low line.
        send_frame(8'h55, 1'b0, 1'b0);
        hold_break(40);
        tick(2 * CPB);
        check_state("after_break");
        check("after_break_busy", 32'(busy), 32'd0);

        // Three-cycle glitch on the idle line.
        RxD = 1'b0;
        tick(3);
        RxD = 1'b1;
        busy_cycles = 0;
        ferr_seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy) busy_cycles++;
            if (frame_err) ferr_seen = 1'b1;
        end
        check("glitch_busy_seen", 32'(busy_cycles > 0), 32'd1);
        check("glitch_busy_le10", 32'(busy_cycles <= 10), 32'd1);
        check("glitch_no_ferr", 32'(ferr_seen), 32'd0);
        check_state("glitch");

        // Reset in the middle of DATA bit 4, with a pending byte to be cleared.
        send_frame(8'h11, 1'b1, 1'b0);
        tick(3);
        RxD = 1'b0;
        tick(CPB);
        RxD = 1'b1;
        tick(4 * CPB + HALF);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        model_reset();
        check_state("mid_rst");
        check("mid_rst_ferr", 32'(frame_err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(5 * CPB);
        send_frame(8'h81, 1'b1, 1'b0);
        check("r81_data", 32'(rx_data), 32'h81);
        check("r81_ovr", 32'(overrun), 32'd0);

        // Acknowledge coinciding with the stop sample: capture wins, no overrun.
        tick(3);
        send_frame(8'h7E, 1'b1, 1'b1);
        check("ackstop_data", 32'(rx_data), 32'h7E);
        check("ackstop_ready", 32'(data_ready), 32'd1);
        check("ackstop_ovr", 32'(overrun), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 24; n++) begin
            rnd_data = 8'($urandom);
            rnd_stop = ($urandom_range(0, 5) != 0);
            mode     = $urandom_range(0, 2);
            send_frame(rnd_data, rnd_stop, mode == 1);
            if (!rnd_stop) begin
                tick(2);
                hold_break($urandom_range(0, 30));
            end
            if (mode == 2) ack_pulse("rnd_ack");
            tick($urandom_range(0, 20));
        end
        check_state("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver. It is the receive end of the 8N1 link whose transmit end drives TxD in the UART top.
- Recovers 8-bit frames from the RxD line: idle high, 1 start bit (low), 8 data bits LSB-first, 1 stop bit (high).
- Each received byte is held in an output register under a ready/acknowledge handshake. Framing-error and overrun flags report bad or lost frames.
- Instantiated in the UART top alongside the transmitter; shares clk and rst.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per bit period (100 MHz / 9600 baud); minimum legal value 4.
- CNT_W, 14, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- RxD  input  1  asynchronous serial line; idles high.
- rd_ack  input  1  consumer acknowledge; one-cycle pulse that clears data_ready.
- rx_data  output  8  last good received byte; stable while data_ready=1.
- data_ready  output  1  level; high from byte capture until rd_ack.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  sticky; set when a good byte arrives while data_ready=1; cleared by rd_ack.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0: rx_data=8'h00, data_ready=0, frame_err=0, overrun=0, busy=0.
  - FSM goes to IDLE. Counters clear. Synchronizer flops preset to 1.
  - A reset mid-frame abandons the frame with no flags raised.
- Input synchronizer: 2-flop chain on RxD; rx_s is the second flop output. All FSM decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s=0, go to START and clear cnt.
  - START: count to CLKS_PER_BIT/2 - 1 (integer division).
    - rx_s=0 at that point: go to DATA, cnt=0, bit_idx=0.
    - rx_s=1 at that point: treat as a glitch and return to IDLE with no flags.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[bit_idx], LSB first.
    - After bit_idx=7 is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s=1: rx_data<=shift; data_ready<=1; return to IDLE.
    - rx_s=0: pulse frame_err for 1 cycle; discard the byte (rx_data and data_ready unchanged); go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This stops a held-low line from being read as back-to-back frames.
- Latency:
  - data_ready rises on the clk edge that samples the stop bit.
  - That edge is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the first clk edge on which RxD is seen low.
  - A returning-to-IDLE receiver accepts a new start edge from the cycle after the stop sample. This tolerates a transmitter running up to ~half a bit fast per frame.
- Handshake and overrun:
  - rd_ack while data_ready=1 clears data_ready and overrun on the next edge.
  - rd_ack while data_ready=0 is ignored.
  - A good stop coinciding with data_ready=1 and no rd_ack: rx_data is overwritten with the new byte, data_ready stays 1, overrun<=1.
  - A good stop coinciding with rd_ack in the same cycle: the capture wins. rx_data = new byte, data_ready=1, overrun=0.
- busy is 0 only in IDLE; it is 1 in BREAK.
- No parity checking; no baud auto-detection.

Test Plan:
- CLKS_PER_BIT=16. Drive frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) -> data_ready rises 2+8+144 cycles after the start edge; rx_data=8'hA5; frame_err=0; overrun=0. Then rd_ack -> data_ready=0 next cycle.
- Send 0x3C then 0xC3 back-to-back without rd_ack -> after the second stop: rx_data=8'hC3, data_ready=1, overrun=1. Then rd_ack -> both flags 0.
- Frame 0x55 with the stop bit driven low, line held low for 40 more cycles, then high -> a single 1-cycle frame_err pulse; rx_data and data_ready unchanged; busy stays 1 until the line goes high; then IDLE. No spurious second frame.
- Low glitch of 3 cycles on an idle line -> START then back to IDLE; no data_ready, no frame_err; busy high for ≤ 8+2 cycles.
- Assert rst at DATA bit 4 of frame 0xFF, then drive a full frame 0x81 -> immediately after reset all outputs are 0; then rx_data=8'h81 with data_ready=1 and no flags.
- rd_ack in the same cycle as the stop sample of 0x7E, with data_ready already 1 -> rx_data=8'h7E, data_ready=1, overrun=0.
